// File: rtl/i2s_pkg.sv
// i2s_pkg: shared mode constants and sizing helpers for the I2S/TDM transmitter
// Contents: I2S_MODE_I2S / I2S_MODE_LJ framing codes, frame_bits(), clog2().
package i2s_pkg;
  localparam logic I2S_MODE_I2S = 1'b0;
  localparam logic I2S_MODE_LJ  = 1'b1;
  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: mclk/sclk toggling, sclk falling-edge event and frame bit counter
// Ports: clk, rst (sync, active-high); i_mclk_en / i_sclk_en toggle strobes;
//   o_mclk, o_sclk clock outputs; o_fe marks an sclk high->low toggle;
//   o_frame_start is o_fe on the counter wrap; o_cnt_nxt is the count after this fe.
module i2s_clkgen #(
  parameter int FB = 64,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_mclk_en,
  input  logic          i_sclk_en,
  output logic          o_mclk,
  output logic          o_sclk,
  output logic          o_fe,
  output logic          o_frame_start,
  output logic [CW-1:0] o_cnt_nxt
);
  localparam logic [CW-1:0] LAST = CW'(FB - 1);
  logic          r_mclk;
  logic          r_sclk;
  logic [CW-1:0] r_cnt;
  assign o_fe          = i_sclk_en && r_sclk;
  assign o_frame_start = o_fe && r_cnt == LAST;
  assign o_cnt_nxt     = r_cnt == LAST ? '0 : r_cnt + 1'b1;
  assign o_mclk        = r_mclk;
  assign o_sclk        = r_sclk;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mclk <= 1'b0;
      r_sclk <= 1'b0;
      r_cnt  <= LAST;
    end else begin
      if (i_mclk_en) r_mclk <= ~r_mclk;
      if (i_sclk_en) r_sclk <= ~r_sclk;
      if (o_fe) r_cnt <= o_cnt_nxt;
    end
  end
endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S/TDM transmit master serialising multi-channel frames onto sdata
// Ports: clk, rst (sync, active-high); mclk_en / sclk_en toggle strobes; mode
//   (0 I2S one-bit delay, 1 left-justified, latched per frame); s_data/s_valid/s_ready
//   frame input, channel 0 in MSBs; mclk, sclk, lrclk, sdata codec pins; underrun pulse.
// Build option: I2S_TX_UNDERRUN_CNT_EN adds the saturating 16-bit underrun_cnt output.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mclk_en,
  input  logic                         sclk_en,
  input  logic                         mode,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         mclk,
  output logic                         sclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                  underrun_cnt
`endif
);
  localparam int FB = frame_bits(CHANNELS, SLOT_W);
  localparam int CW = clog2(FB);
  localparam logic [CW-1:0] HALF = CW'(FB / 2);
  logic                         w_fe;
  logic                         w_fs;
  logic [CW-1:0]                w_cnt_nxt;
  logic                         w_acc;
  logic                         w_mode;
  logic [FB-1:0]                w_load;
  logic [FB-1:0]                w_sh_nxt;
  logic [CHANNELS*SAMPLE_W-1:0] r_hold;
  logic                         r_hold_full;
  logic [FB-1:0]                r_sh;
  logic                         r_mode;
  logic                         r_lrclk;
  logic                         r_sdata;
  logic                         r_underrun;
  i2s_clkgen #(.FB(FB), .CW(CW)) u_clkgen (
    .clk          (clk),
    .rst          (rst),
    .i_mclk_en    (mclk_en),
    .i_sclk_en    (sclk_en),
    .o_mclk       (mclk),
    .o_sclk       (sclk),
    .o_fe         (w_fe),
    .o_frame_start(w_fs),
    .o_cnt_nxt    (w_cnt_nxt)
  );
  assign s_ready  = !r_hold_full;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;
  assign w_acc    = s_valid && !r_hold_full;
  assign w_mode   = w_fs ? mode : r_mode;
  // Spread each channel's sample into the top of its slot; slot tails stay zero.
  always_comb begin
    w_load = '0;
    for (int c = 0; c < CHANNELS; c++)
      w_load[FB-1-c*SLOT_W -: SAMPLE_W] = r_hold[(CHANNELS-c)*SAMPLE_W-1 -: SAMPLE_W];
  end
  assign w_sh_nxt = w_fs ? (r_hold_full ? w_load : '0) : {r_sh[FB-2:0], 1'b0};
  always_ff @(posedge clk) if (w_acc) r_hold <= s_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_sh        <= '0;
      r_mode      <= I2S_MODE_I2S;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_fs && !r_hold_full;
      if (w_acc) r_hold_full <= 1'b1;
      else if (w_fs) r_hold_full <= 1'b0;
      if (w_fe) begin
        r_sh    <= w_sh_nxt;
        r_mode  <= w_mode;
        r_lrclk <= w_cnt_nxt >= HALF;
        // I2S mode re-emits the shifter MSB from before this shift: the one-bit delay.
        r_sdata <= w_mode == I2S_MODE_LJ ? w_sh_nxt[FB-1] : r_sh[FB-1];
      end
    end
  end
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;
  always_ff @(posedge clk) begin
    if (rst) r_ucnt <= '0;
    else if (w_fs && !r_hold_full && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 1'b1;
  end
  assign underrun_cnt = r_ucnt;
`endif
endmodule
